phase_programmer: RTL

PHASE_PROGRAMMER -- requirements
Module: phase_programmer

---
 rtl/phase_programmer.sv | 146 ++++++++++++++
 1 files changed

// File: rtl/phase_programmer.sv
// Per-phase value programmer: LOAD/CONFIRM commits a word to the current phase, END advances.
// Optional readback port enabled by defining PHASE_PROGRAMMER_READBACK_EN.
module phase_programmer #(
    parameter  int unsigned DATA_W     = 4,
    parameter  int unsigned NUM_PHASES = 4,
    localparam int unsigned PHASE_W    = (NUM_PHASES > 2) ? $clog2(NUM_PHASES) : 1
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               cmd_valid,
    input  logic [1:0]         cmd,
    input  logic [DATA_W-1:0]  data,
    input  logic               restart,
    output logic               cmd_ready,
    output logic [PHASE_W-1:0] phase,
    output logic               phase_plus,
    output logic [DATA_W-1:0]  diode,
    output logic               staged,
    output logic               done,
    output logic               err
`ifdef PHASE_PROGRAMMER_READBACK_EN
    ,
    input  logic [PHASE_W-1:0] rd_phase,
    output logic [DATA_W-1:0]  rd_data
`endif
);

    localparam logic [1:0] CMD_LOAD    = 2'b11;
    localparam logic [1:0] CMD_CONFIRM = 2'b01;
    localparam logic [1:0] CMD_END     = 2'b00;
    localparam logic [1:0] CMD_NOP     = 2'b10;

    typedef enum logic [1:0] {
        ST_EMPTY  = 2'd0,
        ST_STAGED = 2'd1,
        ST_DONE   = 2'd2
    } state_t;

    state_t              state_q, state_d;
    logic [PHASE_W-1:0]  phase_q, phase_d, phase_inc;
    logic [DATA_W-1:0]   stage_q, stage_d;
    logic [DATA_W-1:0]   diode_q, diode_d;
    logic                err_q, err_d;
    logic                plus_q, plus_d;
    logic                mem_we;
    logic [DATA_W-1:0]   mem_q [NUM_PHASES];

    assign phase_inc  = phase_q + PHASE_W'(1);
    assign cmd_ready  = (state_q != ST_DONE);
    assign staged     = (state_q == ST_STAGED);
    assign done       = (state_q == ST_DONE);
    assign phase      = phase_q;
    assign diode      = diode_q;
    assign err        = err_q;
    assign phase_plus = plus_q;

    // Next-state and datapath decode; restart overrides any command.
    always_comb begin
        state_d = state_q;
        phase_d = phase_q;
        stage_d = stage_q;
        diode_d = diode_q;
        err_d   = err_q;
        plus_d  = 1'b0;
        mem_we  = 1'b0;
        if (restart) begin
            state_d = ST_EMPTY;
            phase_d = '0;
            err_d   = 1'b0;
            diode_d = mem_q[0];
        end else if (cmd_valid && cmd_ready) begin
            case (cmd)
                CMD_LOAD: begin
                    stage_d = data;
                    state_d = ST_STAGED;
                end
                CMD_CONFIRM: begin
                    if (state_q == ST_STAGED) begin
                        mem_we  = 1'b1;
                        diode_d = stage_q;
                        state_d = ST_EMPTY;
                    end else begin
                        err_d = 1'b1;
                    end
                end
                CMD_END: begin
                    if (state_q == ST_STAGED) begin
                        err_d = 1'b1;
                    end
                    plus_d = 1'b1;
                    if (phase_q == PHASE_W'(NUM_PHASES - 1)) begin
                        state_d = ST_DONE;
                    end else begin
                        phase_d = phase_inc;
                        diode_d = mem_q[phase_inc];
                        state_d = ST_EMPTY;
                    end
                end
                CMD_NOP: ;
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_EMPTY;
            phase_q <= '0;
            stage_q <= '0;
            diode_q <= '0;
            err_q   <= 1'b0;
            plus_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            phase_q <= phase_d;
            stage_q <= stage_d;
            diode_q <= diode_d;
            err_q   <= err_d;
            plus_q  <= plus_d;
        end
    end

    // Committed per-phase storage, survives restart.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < NUM_PHASES; i++) begin
                mem_q[i] <= '0;
            end
        end else if (mem_we) begin
            mem_q[phase_q] <= stage_q;
        end
    end

`ifdef PHASE_PROGRAMMER_READBACK_EN
    // Match loop returns zero for indices beyond the last phase.
    always_comb begin
        rd_data = '0;
        for (int i = 0; i < NUM_PHASES; i++) begin
            if (rd_phase == PHASE_W'(i)) begin
                rd_data = mem_q[i];
            end
        end
    end
`endif

endmodule
